// File: rtl/spi_multi_cs_master_if.sv
// Command/response stream bundle for spi_multi_cs_master.
// The fabric side uses the master modport and the SPI engine uses the slave modport.
interface spi_multi_cs_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8
);
  localparam int CS_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [DATA_WIDTH-1:0] cmd_rw_mask;
  logic [CS_WIDTH-1:0]   cmd_cs;
  logic                  cmd_cpol;
  logic                  cmd_cpha;
  logic [DIV_WIDTH-1:0]  clk_div;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  err;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_len, cmd_data, cmd_rw_mask, cmd_cs, cmd_cpol, cmd_cpha,
           clk_div, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_data, cmd_rw_mask, cmd_cs, cmd_cpol, cmd_cpha,
           clk_div, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, err, busy
  );
endinterface

// File: rtl/spi_multi_cs_master.sv
// Half-duplex 3-wire SPI master with NUM_CS chip selects, per-command CPOL/CPHA and SCLK divider.
// Define SPI_MISO_EN to add spi_miso_i and sample read bits from it instead of spi_sdio_i.
module spi_multi_cs_master #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  fabric_clk,
  input  logic                  reset_n,
  spi_multi_cs_master_if.slave  bus,
  output logic                  spi_sclk_o,
  output logic [NUM_CS-1:0]     spi_cs_n_o,
  output logic                  spi_sdio_o,
  output logic                  spi_sdio_oe_o,
  input  logic                  spi_sdio_i
`ifdef SPI_MISO_EN
  ,
  input  logic                  spi_miso_i
`endif
);
  localparam int CS_WIDTH = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PRE, SETUP, SHIFT, HOLD, GAP, RESP} state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] data_q, mask_q, rsp_q, lmask;
  logic [CS_WIDTH-1:0]   cs_q;
  logic                  cpol_q, cpha_q;
  logic [DIV_WIDTH-1:0]  h_q, cnt_q;
  logic [IDX_W-1:0]      bit_q;
  logic [LEN_WIDTH:0]    ecnt_q;
  logic                  cmd_ready_q, rsp_valid_q, err_q, busy_q;
  logic                  sclk_q, sdo_q, oe_q;
  logic [NUM_CS-1:0]     csn_q;
  logic                  sdi, accept, cmd_bad, tick, last, do_edge;

`ifdef SPI_MISO_EN
  assign sdi = spi_miso_i;
`else
  assign sdi = spi_sdio_i;
`endif

  always_comb begin
    accept  = bus.cmd_valid & cmd_ready_q;
    cmd_bad = (bus.cmd_len == '0) || (int'(bus.cmd_len) > DATA_WIDTH) ||
              (int'(bus.cmd_cs) >= NUM_CS);
    tick    = (cnt_q == h_q - 1'b1);
    last    = (ecnt_q == {len_q, 1'b0});
    // SCLK edges fire on SETUP exit and on every H boundary inside SHIFT
    do_edge = tick & ((state_q == SETUP) | ((state_q == SHIFT) & ~last));
    lmask   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) lmask[i] = (i < int'(len_q));
  end

  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_q       <= '0;
      cs_q        <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      h_q         <= DIV_WIDTH'(1);
      cnt_q       <= '0;
      bit_q       <= '0;
      ecnt_q      <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      csn_q       <= '1;
    end else begin
      err_q <= 1'b0;
      if (state_q inside {SETUP, SHIFT, HOLD, GAP})
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q     <= PRE;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              len_q       <= bus.cmd_len;
              data_q      <= bus.cmd_data;
              mask_q      <= bus.cmd_rw_mask;
              cs_q        <= bus.cmd_cs;
              cpol_q      <= bus.cmd_cpol;
              cpha_q      <= bus.cmd_cpha;
              h_q         <= (bus.clk_div == '0) ? DIV_WIDTH'(1) : bus.clk_div;
              sclk_q      <= bus.cmd_cpol;
              rsp_q       <= '0;
              bit_q       <= IDX_W'(bus.cmd_len - 1'b1);
              ecnt_q      <= '0;
              cnt_q       <= '0;
            end
          end
        end
        PRE: begin
          state_q     <= SETUP;
          csn_q[cs_q] <= 1'b0;
          if (!cpha_q) begin
            oe_q  <= mask_q[bit_q];
            sdo_q <= mask_q[bit_q] & data_q[bit_q];
          end
        end
        SETUP: if (tick) state_q <= SHIFT;
        SHIFT: if (tick && last) begin
          state_q <= HOLD;
          oe_q    <= 1'b0;
          sdo_q   <= 1'b0;
        end
        HOLD: if (tick) begin
          state_q <= GAP;
          csn_q   <= '1;
        end
        GAP: if (tick) begin
          if (|(~mask_q & lmask)) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase

      // Even edge count = leading edge, odd = trailing edge of the current bit
      if (do_edge) begin
        ecnt_q <= ecnt_q + 1'b1;
        if (!ecnt_q[0]) begin
          sclk_q <= ~cpol_q;
          if (!cpha_q) begin
            if (!mask_q[bit_q]) rsp_q[bit_q] <= sdi;
          end else begin
            oe_q  <= mask_q[bit_q];
            sdo_q <= mask_q[bit_q] & data_q[bit_q];
          end
        end else begin
          sclk_q <= cpol_q;
          if (cpha_q && !mask_q[bit_q]) rsp_q[bit_q] <= sdi;
          if (bit_q != '0) begin
            bit_q <= bit_q - 1'b1;
            if (!cpha_q) begin
              oe_q  <= mask_q[bit_q - 1'b1];
              sdo_q <= mask_q[bit_q - 1'b1] & data_q[bit_q - 1'b1];
            end
          end
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign spi_sclk_o    = sclk_q;
  assign spi_cs_n_o    = csn_q;
  assign spi_sdio_o    = sdo_q;
  assign spi_sdio_oe_o = oe_q;
endmodule

// File: tb/tb_spi_multi_cs_master.sv
// Directed bench for spi_multi_cs_master: vector table plus reset/backpressure/cs-range sequences.
// A small SPI device model returns dev_ret bits, shifting on the non-sampling SCLK edge.
module tb_spi_multi_cs_master;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk, o, oe, sdio_i;
  logic [3:0] cs_n;
  logic       sclk3, o3, oe3;
  logic [2:0] cs_n3;

  always #5 clk = ~clk;

  spi_multi_cs_master_if #(.DATA_WIDTH(32), .LEN_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) bus ();
  spi_multi_cs_master_if #(.DATA_WIDTH(32), .LEN_WIDTH(8), .NUM_CS(3), .DIV_WIDTH(8)) bus3 ();

  spi_multi_cs_master #(.DATA_WIDTH(32), .LEN_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) u_dut (
    .fabric_clk(clk), .reset_n(reset_n), .bus(bus),
    .spi_sclk_o(sclk), .spi_cs_n_o(cs_n), .spi_sdio_o(o), .spi_sdio_oe_o(oe),
    .spi_sdio_i(sdio_i)
`ifdef SPI_MISO_EN
    , .spi_miso_i(sdio_i)
`endif
  );

  spi_multi_cs_master #(.DATA_WIDTH(32), .LEN_WIDTH(8), .NUM_CS(3), .DIV_WIDTH(8)) u_dut3 (
    .fabric_clk(clk), .reset_n(reset_n), .bus(bus3),
    .spi_sclk_o(sclk3), .spi_cs_n_o(cs_n3), .spi_sdio_o(o3), .spi_sdio_oe_o(oe3),
    .spi_sdio_i(1'b0)
`ifdef SPI_MISO_EN
    , .spi_miso_i(1'b0)
`endif
  );

  // Device model
  int          dev_len = 1, dev_ptr = -1;
  logic        dev_cpol = 1'b0, dev_cpha = 1'b0;
  logic [31:0] dev_ret = '0;
  logic        cs_act, cs_act_prev = 1'b0, sclk_prev = 1'b0;
  assign cs_act = ~&cs_n;
  always @(sclk or cs_act) begin
    if (cs_act && !cs_act_prev) dev_ptr = dev_len - 1 + int'(dev_cpha);
    else if (cs_act && sclk != sclk_prev && sclk == (dev_cpol ^ dev_cpha)) dev_ptr--;
    cs_act_prev = cs_act;
    sclk_prev   = sclk;
  end
  assign sdio_i = (dev_ptr >= 0 && dev_ptr < 32) ? dev_ret[dev_ptr[4:0]] : 1'b0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    int          len;
    logic [31:0] data, mask;
    int          cs;
    logic        cpol, cpha;
    int          div;
    logic [31:0] ret;
    logic        e_err, e_rsp;
    logic [31:0] e_rdata, e_o, e_oe;
    logic [3:0]  e_csn;
    int          e_cyc, e_cslow;
  } vec_t;

  vec_t vt[7];

  task automatic issue(input vec_t v, input bit keep_valid);
    dev_len = v.len; dev_cpol = v.cpol; dev_cpha = v.cpha; dev_ret = v.ret;
    for (int i = 0; i < 200 && !bus.cmd_ready; i++) @(negedge clk);
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_len = 8'(v.len);  bus.cmd_data = v.data; bus.cmd_rw_mask = v.mask;
    bus.cmd_cs  = 2'(v.cs);   bus.cmd_cpol = v.cpol; bus.cmd_cpha = v.cpha;
    bus.clk_div = 8'(v.div);  bus.cmd_valid = 1'b1;
    if (!keep_valid) begin
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, cslow, edges;
    logic [31:0] co, coe;
    logic [3:0]  csn_seen;
    logic        prev_sclk, sclk_at_cs, first, busy_ok, slvl;
    issue(v, 1'b0);
    if (v.e_err) begin
      chk($sformatf("v%0d_err_pulse", idx), bus.err, 1);
      chk($sformatf("v%0d_err_csn", idx), cs_n, 4'hF);
      chk($sformatf("v%0d_err_busy", idx), bus.busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_err_clear", idx), {bus.err, bus.cmd_ready, cs_n}, {2'b01, 4'hF});
      chk($sformatf("v%0d_err_norsp", idx), bus.rsp_valid, 0);
      return;
    end
    cyc = 1; cslow = 0; edges = 0; co = '0; coe = '0; csn_seen = 4'hF;
    first = 1'b1; busy_ok = 1'b1; sclk_at_cs = 1'bx; prev_sclk = sclk;
    slvl = v.cpol ^ ~v.cpha;
    while (cyc < 500 && !bus.cmd_ready && !bus.rsp_valid) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (cs_n != 4'hF) begin
        cslow++;
        csn_seen = cs_n;
        if (first) sclk_at_cs = sclk;
        first = 1'b0;
      end
      if (sclk != prev_sclk) begin
        edges++;
        if (sclk == slvl) begin
          co  = {co[30:0], oe & o};
          coe = {coe[30:0], oe};
        end
      end
      prev_sclk = sclk;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_cycles", idx), cyc, v.e_cyc);
    chk($sformatf("v%0d_csn", idx), csn_seen, v.e_csn);
    chk($sformatf("v%0d_cs_low_cycles", idx), cslow, v.e_cslow);
    chk($sformatf("v%0d_sclk_edges", idx), edges, 2 * v.len);
    chk($sformatf("v%0d_sclk_idle", idx), sclk_at_cs, v.cpol);
    chk($sformatf("v%0d_sdio_o", idx), co, v.e_o);
    chk($sformatf("v%0d_sdio_oe", idx), coe, v.e_oe);
    chk($sformatf("v%0d_busy", idx), busy_ok, 1);
    chk($sformatf("v%0d_rsp_valid", idx), bus.rsp_valid, v.e_rsp);
    if (v.e_rsp) begin
      chk($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.e_rdata);
      chk($sformatf("v%0d_ready_in_resp", idx), bus.cmd_ready, 0);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk($sformatf("v%0d_after_hs", idx), {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    end
  endtask

  initial begin
    logic hold_ok;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0; bus.cmd_len = '0; bus.cmd_data = '0;
    bus.cmd_rw_mask = '0; bus.cmd_cs = '0; bus.cmd_cpol = 1'b0; bus.cmd_cpha = 1'b0;
    bus.clk_div = '0;
    bus3.cmd_valid = 1'b0; bus3.rsp_ready = 1'b0; bus3.cmd_len = '0; bus3.cmd_data = '0;
    bus3.cmd_rw_mask = '0; bus3.cmd_cs = '0; bus3.cmd_cpol = 1'b0; bus3.cmd_cpha = 1'b0;
    bus3.clk_div = '0;

    //        len data          mask          cs cpol cpha div ret         err rsp rdata  o             oe            csn  cyc cslow
    vt[0] = '{8,  32'hA5,       32'hFF,       0, 0,   0,   2,  32'h0,      0,  0,  32'h0, 32'hA5,       32'hFF,       4'hE, 40, 36};
    vt[1] = '{16, 32'h8000,     32'hFF00,     1, 0,   0,   1,  32'h3C,     0,  1,  32'h3C, 32'h8000,    32'hFF00,     4'hD, 37, 34};
    vt[2] = '{4,  32'h0,        32'h0,        2, 1,   1,   0,  32'h9,      0,  1,  32'h9, 32'h0,        32'h0,        4'hB, 13, 10};
    vt[3] = '{0,  32'h1,        32'h1,        0, 0,   0,   1,  32'h0,      1,  0,  32'h0, 32'h0,        32'h0,        4'hF, 0,  0};
    vt[4] = '{33, 32'h1,        32'h1,        0, 0,   0,   1,  32'h0,      1,  0,  32'h0, 32'h0,        32'h0,        4'hF, 0,  0};
    vt[5] = '{32, 32'hDEADBEEF, 32'hFFFFFFFF, 3, 0,   1,   1,  32'h0,      0,  0,  32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 4'h7, 69, 66};
    vt[6] = '{5,  32'h10,       32'h18,       0, 1,   0,   3,  32'h5,      0,  1,  32'h5, 32'h10,       32'h18,       4'hE, 41, 36};

    // Reset behaviour
    repeat (5) @(negedge clk);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_spi", {sclk, o, oe}, 3'b000);
    chk("rst_flags", {bus.cmd_ready, bus.rsp_valid, bus.err, bus.busy}, 4'b0000);
    chk("rst_rsp_data", bus.rsp_data, 0);
    reset_n = 1'b1;
    #1 chk("rel_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    chk("rel_ready_high", bus.cmd_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Chip-select index out of range on a 3-CS instance
    bus3.cmd_len = 8'd8; bus3.cmd_cs = 2'd3; bus3.clk_div = 8'd1; bus3.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.cmd_valid = 1'b0;
    chk("cs3_err_pulse", {bus3.err, bus3.busy, cs_n3}, {2'b10, 3'b111});
    @(negedge clk);
    chk("cs3_err_clear", {bus3.err, bus3.cmd_ready, cs_n3}, {2'b01, 3'b111});

    // Backpressure: response held, second command waits for the handshake
    issue(vt[2], 1'b0);
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) @(negedge clk);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    bus.cmd_len = 8'd8; bus.cmd_data = 32'hA5; bus.cmd_rw_mask = 32'hFF; bus.cmd_cs = 2'd0;
    bus.cmd_cpol = 1'b0; bus.cmd_cpha = 1'b0; bus.clk_div = 8'd2; bus.cmd_valid = 1'b1;
    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 32'h9 || bus.cmd_ready || cs_n !== 4'hF)
        hold_ok = 1'b0;
    end
    chk("bp_hold", hold_ok, 1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_released", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_second_accepted", {bus.busy, bus.cmd_ready}, 2'b10);
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
    chk("bp_second_done", {bus.cmd_ready, bus.rsp_valid}, 2'b10);

    // Reset mid-SHIFT
    issue(vt[0], 1'b0);
    repeat (9) @(negedge clk);
    chk("mid_active", {bus.busy, cs_n}, {1'b1, 4'hE});
    reset_n = 1'b0;
    #1 chk("mid_rst_spi", {cs_n, sclk, oe}, {4'hF, 2'b00});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle", {bus.rsp_valid, bus.cmd_ready, bus.busy, cs_n}, {3'b010, 4'hF});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
